// File: rtl/bios_loader.sv
// BIOS download writer: ioctl byte stream -> small FIFO -> paced single-cycle memory writes.
// The optional running byte checksum output is enabled by defining BIOS_LOADER_CHECKSUM_EN.
module bios_loader #(
  parameter logic [7:0]  LOAD_INDEX = 8'h00,
  parameter logic [15:0] BASE_ADDR  = 16'hE000,
  parameter int          LOAD_LEN   = 8192,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clka,
  input  logic        resetn,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        cpu_en,
  input  logic [15:0] cpu_addr,
  output logic        cpu_hold,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        load_done,
  output logic        bios_valid,
  output logic        overflow
`ifdef BIOS_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [24:0]   LEN_C  = 25'(LOAD_LEN);
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_C = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [15:0] off;
    logic [7:0]  data;
  } entry_t;

  state_t        r_state, w_nxt;
  entry_t        r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_dl_q, r_we, r_wait, r_bios_valid, r_ovf;
  logic [15:0]   r_addr;
  logic [7:0]    r_din;
  logic          w_empty, w_full, w_in_range, w_push, w_pop, w_drop, w_busy;
  entry_t        w_head;

  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == FULL_C);
  assign w_in_range = (ioctl_addr < LEN_C);
  assign w_push     = (r_state == LOAD) && ioctl_wr && w_in_range && !w_full;
  assign w_drop     = (r_state == LOAD) && ioctl_wr && w_in_range && w_full;
  assign w_pop      = ((r_state == LOAD) || (r_state == DRAIN)) && !w_empty;
  assign w_cnt_nxt  = r_cnt + CW'(w_push) - CW'(w_pop);
  assign w_head     = r_fifo[r_rp];

  // State register
  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_nxt;
  end

  // Only a rising edge of ioctl_download starts a load, so a download that
  // re-asserts while draining is not picked up once IDLE is reached.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:  if (ioctl_download && !r_dl_q && (ioctl_index == LOAD_INDEX)) w_nxt = LOAD;
      LOAD:  if (!ioctl_download) w_nxt = DRAIN;
      DRAIN: if (w_empty && !r_we) w_nxt = DONE;
      DONE:  w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Memory port: owned by the loader outside IDLE, CPU pass-through otherwise
  always_comb begin
    w_busy    = (r_state != IDLE);
    load_done = (r_state == DONE);
    if (w_busy) begin
      mem_en   = r_we;
      mem_we   = r_we;
      mem_addr = r_addr;
    end else begin
      mem_en   = cpu_en;
      mem_we   = 1'b0;
      mem_addr = cpu_addr;
    end
  end

  assign cpu_hold   = w_busy;
  assign mem_din    = r_din;
  assign ioctl_wait = r_wait;
  assign bios_valid = r_bios_valid;
  assign overflow   = r_ovf;

  always_ff @(posedge clka) begin
    if (w_push) r_fifo[r_wp] <= {ioctl_addr[15:0], ioctl_dout};
  end

  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn) begin
      r_dl_q       <= 1'b0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_wait       <= 1'b0;
      r_bios_valid <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_dl_q <= ioctl_download;
      r_cnt  <= w_cnt_nxt;
      r_we   <= w_pop;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp   <= r_rp + 1'b1;
        r_addr <= BASE_ADDR + w_head.off;
        r_din  <= w_head.data;
      end
      r_wait <= (w_nxt == LOAD) && (w_cnt_nxt >= WAIT_C);
      if (r_state == DONE) r_bios_valid <= 1'b1;
      if (w_drop)          r_ovf        <= 1'b1;
    end
  end

`ifdef BIOS_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  // Summed at pop time; every pop becomes exactly one memory write next cycle
  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn)                               r_csum <= '0;
    else if ((r_state == IDLE) && (w_nxt == LOAD)) r_csum <= '0;
    else if (w_pop)                            r_csum <= r_csum + w_head.data;
  end

  assign checksum = r_csum;
`endif

endmodule

// File: tb/tb_bios_loader.sv
// Scoreboard bench for bios_loader: expected memory writes are queued at stimulus
// time and checked by a separate monitor whenever the DUT presents mem_we.
module tb_bios_loader;

  logic        clka = 1'b0;
  logic        resetn = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        cpu_en = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        cpu_hold, mem_en, mem_we, load_done, bios_valid, overflow;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
`ifdef BIOS_LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  bios_loader dut (
    .clka(clka), .resetn(resetn),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_hold(cpu_hold),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .load_done(load_done), .bios_valid(bios_valid), .overflow(overflow)
`ifdef BIOS_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clka = ~clka;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          cyc;   // negative: timing not checked
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always @(posedge clka) cyc <= cyc + 1;

  // Monitor: every memory write must match the head of the scoreboard
  always @(negedge clka) begin
    if (resetn) begin
      if (load_done) done_cnt++;
      if (mem_we) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr=%h data=%h cyc=%0d", mem_addr, mem_din, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (mem_addr !== e.a || mem_din !== e.d || mem_en !== 1'b1 ||
              (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL mem_write got addr=%h data=%h en=%b cyc=%0d want addr=%h data=%h cyc=%0d",
                     mem_addr, mem_din, mem_en, cyc, e.a, e.d, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d,
                         input logic [15:0] exp_a, input bit expect_wr, input bit timed);
    exp_t e;
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (expect_wr) begin
      e.a = exp_a; e.d = d; e.cyc = timed ? cyc + 2 : -1;
      q.push_back(e);
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl_wait(input string name);
    int base, n;
    base = done_cnt;
    n = 0;
    ioctl_download = 1'b0;
    while (done_cnt == base && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk({name, "_done_pulses"}, 32'(done_cnt), 32'(base + 1));
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_valid", 32'(bios_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    resetn = 1'b1;
    tick();

    // CPU pass-through
    cpu_en = 1'b1; cpu_addr = 16'hFFF0;
    #1;
    chk("cpu_en", 32'(mem_en), 32'd1);
    chk("cpu_we", 32'(mem_we), 32'd0);
    chk("cpu_addr", 32'(mem_addr), 32'h0000FFF0);
    chk("cpu_hold", 32'(cpu_hold), 32'd0);
    tick();
    cpu_en = 1'b0;

    // Basic three-byte load
    start_dl(8'h00);
    chk("load_hold", 32'(cpu_hold), 32'd1);
    wr_byte(25'd0, 8'h11, 16'hE000, 1'b1, 1'b1);
    wr_byte(25'd1, 8'h22, 16'hE001, 1'b1, 1'b1);
    wr_byte(25'd2, 8'h33, 16'hE002, 1'b1, 1'b1);
    end_dl_wait("basic");
    chk("basic_valid", 32'(bios_valid), 32'd1);
    chk("basic_hold_after", 32'(cpu_hold), 32'd0);
    chk("basic_q_empty", 32'(q.size()), 32'd0);
`ifdef BIOS_LOADER_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'h66);
`endif

    // Wrong index: nothing happens
    begin
      int base;
      base = done_cnt;
      start_dl(8'h01);
      chk("idx1_hold", 32'(cpu_hold), 32'd0);
      wr_byte(25'd0, 8'h99, 16'h0, 1'b0, 1'b0);
      wr_byte(25'd1, 8'h98, 16'h0, 1'b0, 1'b0);
      ioctl_download = 1'b0;
      repeat (10) tick();
      chk("idx1_no_done", 32'(done_cnt), 32'(base));
      chk("idx1_hold_after", 32'(cpu_hold), 32'd0);
    end

    // Length boundary
    start_dl(8'h00);
    wr_byte(25'd8192, 8'hAA, 16'h0, 1'b0, 1'b0);
    wr_byte(25'd8191, 8'h5C, 16'hFFFF, 1'b1, 1'b1);
    end_dl_wait("bound");
    chk("bound_ovf", 32'(overflow), 32'd0);
    chk("bound_q_empty", 32'(q.size()), 32'd0);

    // Six back-to-back strobes keep up, then a stalled drain overflows
    start_dl(8'h00);
    for (int i = 0; i < 6; i++)
      wr_byte(25'(i), 8'(8'h40 + i), 16'(16'hE000 + i), 1'b1, 1'b1);
    chk("six_wait", 32'(ioctl_wait), 32'd0);
    repeat (3) tick();
    chk("six_ovf", 32'(overflow), 32'd0);
    chk("six_q_empty", 32'(q.size()), 32'd0);
    force dut.w_pop = 1'b0;
    for (int i = 0; i < 5; i++)
      wr_byte(25'(16 + i), 8'(8'hC0 + i), 16'(16'hE010 + i), i < 4, 1'b0);
    chk("full_wait", 32'(ioctl_wait), 32'd1);
    chk("full_ovf", 32'(overflow), 32'd1);
    release dut.w_pop;
    repeat (8) tick();
    end_dl_wait("full");
    chk("full_q_empty", 32'(q.size()), 32'd0);
    chk("full_wait_idle", 32'(ioctl_wait), 32'd0);

    // Reset mid-download: second byte is still queued and must be abandoned
    start_dl(8'h00);
    wr_byte(25'd0, 8'h77, 16'hE000, 1'b1, 1'b1);
    wr_byte(25'd1, 8'h88, 16'h0, 1'b0, 1'b0);
    @(negedge clka);
    #1;
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bios_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
    chk("mid_rst_wait", 32'(ioctl_wait), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
`ifdef BIOS_LOADER_CHECKSUM_EN
    chk("mid_rst_csum", 32'(checksum), 32'd0);
`endif
    ioctl_download = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    wr_byte(25'd2, 8'h99, 16'h0, 1'b0, 1'b0);
    wr_byte(25'd3, 8'h9A, 16'h0, 1'b0, 1'b0);
    repeat (6) tick();
    chk("post_rst_q_empty", 32'(q.size()), 32'd0);
    chk("post_rst_valid", 32'(bios_valid), 32'd0);
    chk("post_rst_hold", 32'(cpu_hold), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
